debounce_fsm: RTL

Debounces a raw, bouncy mechanical input (push-button or slide switch) into a clean level. The block sits directly upstream of the rising-edge detectors: its `db_level` output drives their `level` input, so each physical press yields exactly one tick. It is a four-state Moore FSM with a down-counter that requires the input to hold steady for a programmable number of cycles before the output level changes.

---
 rtl/debounce_fsm.sv | 50 +++++
 1 files changed

// File: rtl/debounce_fsm.sv
// debounce_fsm: Moore debouncer that qualifies a level change over STABLE_CYC+1 equal samples.
// Optional DEBOUNCE_SYNC_EN inserts a 2-flop synchronizer on sw.
module debounce_fsm #(
  parameter int STABLE_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic db_level,
  output logic busy
);
  localparam int W = STABLE_CYC > 1 ? $clog2(STABLE_CYC) : 1;
  localparam logic [W-1:0] LOAD = W'(STABLE_CYC - 1);
  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;
  state_t st, nxt;
  logic [W-1:0] cnt, cnt_nxt;
  logic s;
`ifdef DEBOUNCE_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk or negedge rst)
    if (!rst) sync <= '0;
    else sync <= {sync[0], sw};
  assign s = sync[1];
`else
  assign s = sw;
`endif
  always_comb begin
    nxt = st;
    cnt_nxt = cnt;
    case (st)
      ZERO:  if (s) begin nxt = WAIT1; cnt_nxt = LOAD; end
      WAIT1: if (!s) nxt = ZERO; else if (cnt == '0) nxt = ONE; else cnt_nxt = cnt - 1'b1;
      ONE:   if (!s) begin nxt = WAIT0; cnt_nxt = LOAD; end
      WAIT0: if (s) nxt = ONE; else if (cnt == '0) nxt = ZERO; else cnt_nxt = cnt - 1'b1;
    endcase
  end
  // outputs decoded from next state so they are flops aligned with the state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= ZERO;
      cnt <= '0;
      db_level <= 1'b0;
      busy <= 1'b0;
    end else begin
      st <= nxt;
      cnt <= cnt_nxt;
      db_level <= nxt == ONE || nxt == WAIT0;
      busy <= nxt == WAIT1 || nxt == WAIT0;
    end
endmodule
